// File: rtl/ram_lsu_adapter.sv
// Byte-addressed load/store front end for a single-port, async-read, byte-strobed 32-bit RAM.
// Accesses that straddle a word boundary take two RAM cycles; each request gets one response.
module ram_lsu_adapter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_split,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [3:0]            ram_wstrb,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] n,
                                         input logic sgn);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{sgn & data[7]}}, data[7:0]};
      3'd2:    r = {{16{sgn & data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] w_q, w_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            n_q, n_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           low_q, low_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_split_q, resp_split_d;

  logic [ADDR_WIDTH-1:0] req_w;
  logic [1:0]            req_off;
  logic [2:0]            req_n;
  logic                  req_split;
  logic [4:0]            req_sh;
  logic [7:0]            req_mask;
  logic [5:0]            held_sh;
  logic [7:0]            held_mask;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [3:0]            wstrb_c;
  logic [31:0]           wdata_c;

  assign req_w     = req_addr[ADDR_WIDTH+1:2];
  assign req_off   = req_addr[1:0];
  assign req_n     = size_bytes(req_size);
  assign req_split = (({1'b0, req_off} + req_n) > 3'd4);
  assign req_sh    = {req_off, 3'b000};
  assign req_mask  = {4'b0000, lane_mask(req_n)} << req_off;

  // Upper nibble of the shifted mask is exactly the set of lanes spilling into word w+1.
  assign held_sh   = {3'd4 - {1'b0, off_q}, 3'b000};
  assign held_mask = {4'b0000, lane_mask(n_q)} << off_q;

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    off_d        = off_q;
    n_d          = n_q;
    write_d      = write_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    low_d        = low_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_split_d = resp_split_q;
    ram_addr_c   = req_w;
    wstrb_c      = 4'b0000;
    wdata_c      = 32'h0000_0000;

    req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    accept    = req_valid && req_ready;

    if (state_q == SECOND) begin
      ram_addr_c = w_q + ADDR_WIDTH'(1);
      if (write_q) begin
        wstrb_c      = held_mask[7:4];
        wdata_c      = wdata_q >> held_sh;
        resp_rdata_d = 32'h0000_0000;
      end else begin
        resp_rdata_d = extend(low_q | (ram_rdata << held_sh), n_q, signed_q);
      end
      resp_valid_d = 1'b1;
      resp_split_d = 1'b1;
      state_d      = RESP;
    end else begin
      if ((state_q == RESP) && resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      if (accept) begin
        if (req_write) begin
          wstrb_c = req_mask[3:0];
          wdata_c = req_wdata << req_sh;
        end
        if (req_split) begin
          w_d          = req_w;
          off_d        = req_off;
          n_d          = req_n;
          write_d      = req_write;
          signed_d     = req_signed;
          wdata_d      = req_wdata;
          low_d        = ram_rdata >> req_sh;
          resp_valid_d = 1'b0;
          state_d      = SECOND;
        end else begin
          resp_valid_d = 1'b1;
          resp_split_d = 1'b0;
          resp_rdata_d = req_write ? 32'h0000_0000
                                   : extend(ram_rdata >> req_sh, req_n, req_signed);
          state_d      = RESP;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      w_q          <= '0;
      off_q        <= '0;
      n_q          <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      low_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_split_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      off_q        <= off_d;
      n_q          <= n_d;
      write_q      <= write_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      low_q        <= low_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_split_q <= resp_split_d;
    end
  end

  // Gate strobes directly on reset so an in-flight second-half write is dropped at once.
  assign ram_wstrb  = reset ? 4'b0000 : wstrb_c;
  assign ram_wdata  = wdata_c;
  assign ram_raddr  = ram_addr_c;
  assign ram_waddr  = ram_addr_c;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_split = resp_split_q;

endmodule

// File: tb/tb_ram_lsu_adapter.sv
// Bench for ram_lsu_adapter: behavioural byte-array memory model, directed plan steps,
// then randomized accesses over a low and a wrapping top address window.
module tb_ram_lsu_adapter;

  localparam int AW = 12;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW+1:0] req_addr;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_split;
  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_waddr;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int errors = 0;
  int checks = 0;

  // Environment RAM: async read, byte-strobed synchronous write, plus a preload port.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_idx;
  logic [31:0]   pl_data;

  // Reference memory, byte granular.
  logic [7:0]    mdl [0:(1<<(AW+2))-1];

  ram_lsu_adapter #(.ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_split (resp_split),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_wstrb  (ram_wstrb),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_rdata = mem[ram_raddr];

  always @(posedge clock) begin
    if (pl_we) begin
      mem[pl_idx] <= pl_data;
    end else begin
      for (int k = 0; k < 4; k++)
        if (ram_wstrb[k]) mem[ram_waddr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [AW+1:0] a, input logic [1:0] sz,
                                             input logic sg);
    int          n;
    logic [31:0] r;
    logic [AW+1:0] b;
    n = nbytes(sz);
    r = '0;
    for (int i = 0; i < n; i++) begin
      b = a + (AW+2)'(i);
      r[8*i +: 8] = mdl[b];
    end
    if (sg && n < 4)
      for (int j = 8*n; j < 32; j++) r[j] = r[8*n-1];
    return r;
  endfunction

  // One complete transaction from IDLE through response consumption.
  task automatic do_req(input logic [AW+1:0] a, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, output logic [31:0] rd);
    int            n;
    logic [AW+1:0] b;
    logic [AW-1:0] w0, w1;
    logic [3:0]    s0, s1;
    logic [31:0]   d0, d1, m0, m1, exp_rd;
    logic          spl;
    n  = nbytes(sz);
    w0 = a[AW+1:2];
    w1 = w0 + AW'(1);
    s0 = '0; s1 = '0; d0 = '0; d1 = '0; m0 = '0; m1 = '0;
    for (int i = 0; i < n; i++) begin
      b = a + (AW+2)'(i);
      if (b[AW+1:2] == w0) begin
        s0[b[1:0]] = 1'b1;
        d0[8*b[1:0] +: 8] = wd[8*i +: 8];
        m0[8*b[1:0] +: 8] = 8'hFF;
      end else begin
        s1[b[1:0]] = 1'b1;
        d1[8*b[1:0] +: 8] = wd[8*i +: 8];
        m1[8*b[1:0] +: 8] = 8'hFF;
      end
    end
    spl    = (s1 != 4'b0000);
    exp_rd = wr ? 32'h0 : model_load(a, sz, sg);

    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_write = wr; req_size = sz;
    req_signed = sg; req_wdata = wd; resp_ready = 1'b0;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("raddr_first", 32'(ram_raddr), 32'(w0));
    check("waddr_first", 32'(ram_waddr), 32'(w0));
    check("wstrb_first", 32'(ram_wstrb), wr ? 32'(s0) : 32'd0);
    if (wr) check("wdata_first", ram_wdata & m0, d0);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = (AW+2)'($urandom); req_wdata = $urandom;
    req_size = 2'($urandom); req_signed = 1'($urandom); req_write = 1'($urandom);
    check("latency_first", 32'(resp_valid), 32'(!spl));
    if (spl) begin
      check("req_ready_second", 32'(req_ready), 32'd0);
      check("waddr_second", 32'(ram_waddr), 32'(w1));
      check("wstrb_second", 32'(ram_wstrb), wr ? 32'(s1) : 32'd0);
      if (wr) check("wdata_second", ram_wdata & m1, d1);
      @(posedge clock); #1;
      check("latency_second", 32'(resp_valid), 32'd1);
    end
    check("resp_split", 32'(resp_split), 32'(spl));
    check("resp_rdata", resp_rdata, exp_rd);
    rd = resp_rdata;
    if (wr)
      for (int i = 0; i < n; i++) begin
        b = a + (AW+2)'(i);
        mdl[b] = wd[8*i +: 8];
      end
    $display("txn addr=%h wr=%0d size=%0d signed=%0d wdata=%h rdata=%h split=%0d",
             a, wr, sz, sg, wd, rd, spl);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_consumed", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0]   rd;
    logic [31:0]   saved;
    logic [31:0]   exp_a, exp_b;
    logic [AW+1:0] ra;
    logic [AW-1:0] idx;

    reset = 1'b1; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
    req_valid = 1'b1; req_addr = 14'h010; req_write = 1'b1; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'hFFFF_FFFF; resp_ready = 1'b0;

    // Preload the low window (words 0..15) and the top window (words 4092..4095).
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      idx = (i < 16) ? AW'(i) : AW'(4076 + i);
      pl_we = 1'b1; pl_idx = idx; pl_data = $urandom;
      for (int k = 0; k < 4; k++) mdl[{idx, 2'(k)}] = pl_data[8*k +: 8];
    end
    @(negedge clock);
    pl_we = 1'b0;
    #1;
    check("reset_wstrb", 32'(ram_wstrb), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_split", 32'(resp_split), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Aligned word store/load.
    do_req(14'h010, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, rd);
    do_req(14'h010, 1'b0, 2'd2, 1'b0, 32'h0, rd);
    check("plan_word_load", rd, 32'hDEAD_BEEF);

    // Byte/half extension from word 4 = 0x12805634.
    do_req(14'h010, 1'b1, 2'd2, 1'b0, 32'h1280_5634, rd);
    do_req(14'h012, 1'b0, 2'd0, 1'b1, 32'h0, rd);
    check("plan_byte_signed", rd, 32'hFFFF_FF80);
    do_req(14'h012, 1'b0, 2'd0, 1'b0, 32'h0, rd);
    check("plan_byte_unsigned", rd, 32'h0000_0080);
    do_req(14'h012, 1'b0, 2'd1, 1'b1, 32'h0, rd);
    check("plan_half_signed", rd, 32'h0000_1280);

    // Split half store and reload.
    do_req(14'h013, 1'b1, 2'd1, 1'b0, 32'h0000_AABB, rd);
    do_req(14'h013, 1'b0, 2'd1, 1'b0, 32'h0, rd);
    check("plan_split_half", rd, 32'h0000_AABB);

    // Wrapping word store at the top of the address space, then reload.
    do_req(14'h3FFE, 1'b1, 2'd2, 1'b0, 32'h1122_3344, rd);
    do_req(14'h3FFE, 1'b0, 2'd3, 1'b0, 32'h0, rd);
    check("plan_wrap_load", rd, 32'h1122_3344);

    // Backpressure for five cycles, then a same-cycle handoff to a new request.
    exp_a = model_load(14'h010, 2'd2, 1'b0);
    exp_b = model_load(14'h014, 2'd2, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 14'h010; req_write = 1'b0; req_size = 2'd2;
    req_signed = 1'b0; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_rdata", resp_rdata, exp_a);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 14'h014;
    #1;
    check("b2b_req_ready", 32'(req_ready), 32'd1);
    check("b2b_raddr", 32'(ram_raddr), 32'd5);
    @(posedge clock); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    check("b2b_resp_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp_rdata", resp_rdata, exp_b);
    $display("txn b2b addr=014 rdata=%h", resp_rdata);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("b2b_consumed", 32'(resp_valid), 32'd0);

    // Reset during the second half of a split store (words 9 and 10).
    saved = mem[10];
    @(negedge clock);
    req_valid = 1'b1; req_addr = 14'h027; req_write = 1'b1; req_size = 2'd2;
    req_signed = 1'b0; req_wdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rst2_wstrb_before", 32'(ram_wstrb), 32'b0111);
    reset = 1'b1;
    #1;
    check("rst2_wstrb_forced", 32'(ram_wstrb), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    mdl[14'h027] = 8'h0D;
    check("rst2_word_unchanged", mem[10], saved);
    check("rst2_resp_valid", 32'(resp_valid), 32'd0);
    check("rst2_req_ready", 32'(req_ready), 32'd1);
    $display("txn reset_in_second addr=027 word10=%h", mem[10]);

    // Randomized accesses over both preloaded windows.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) ra = (AW+2)'($urandom_range(16368, 16383));
      else                           ra = (AW+2)'($urandom_range(0, 60));
      do_req(ra, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, rd);
    end

    // Final memory image against the reference.
    for (int i = 0; i < 20; i++) begin
      idx = (i < 16) ? AW'(i) : AW'(4076 + i);
      check("mem_image", mem[idx],
            {mdl[{idx, 2'd3}], mdl[{idx, 2'd2}], mdl[{idx, 2'd1}], mdl[{idx, 2'd0}]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
